// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fetch_pkg
// Purpose  : Shared FSM encoding, default widths and clog2 for the fetch stage.
// Revision : 1.0 - initial release
// ============================================================================
package fetch_pkg;

  localparam int unsigned DEF_PC_W    = 32;
  localparam int unsigned DEF_INSTR_W = 32;
  localparam int unsigned DEF_DEPTH   = 4;
  localparam int unsigned DEF_PC_STEP = 4;

  typedef enum logic [1:0] {
    ST_BOOT   = 2'd0,
    ST_RUN    = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_HALTED = 2'd3
  } fetch_state_e;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    int unsigned v;
    result = 0;
    v      = (value > 0) ? value - 1 : 0;
    while (v > 0) begin
      result = result + 1;
      v      = v >> 1;
    end
    return result;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
// Module   : fetch_fifo
// Purpose  : DEPTH-entry circular buffer with push, pop, clear and occupancy.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter  int unsigned DEPTH = DEF_DEPTH,
  parameter  int unsigned WIDTH = DEF_INSTR_W + DEF_PC_W,
  localparam int unsigned AW    = clog2(DEPTH),
  localparam int unsigned CW    = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic             clear,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic [CW-1:0]    count
);

  localparam logic [AW-1:0] PTR_MASK = AW'(DEPTH - 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    count_q, count_d;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (clear) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = (wr_ptr_q + AW'(1)) & PTR_MASK;
      if (pop)  rd_ptr_d = (rd_ptr_q + AW'(1)) & PTR_MASK;
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  // Storage is reset so the head reads as zero straight out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      if (push && !clear) mem_q[wr_ptr_q] <= wdata;
    end
  end

  assign rdata = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : fetch_queue
// Purpose  : Fetch stage: PC generation, 1-cycle imem reads, buffered hand-off.
//            Optional macro FETCH_PERF_CNT_EN adds perf_fetched/perf_flushed.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_queue
  import fetch_pkg::*;
#(
  parameter  int unsigned     PC_W     = DEF_PC_W,
  parameter  int unsigned     INSTR_W  = DEF_INSTR_W,
  parameter  int unsigned     DEPTH    = DEF_DEPTH,
  parameter  logic [PC_W-1:0] RESET_PC = '0,
  parameter  int unsigned     PC_STEP  = DEF_PC_STEP,
  localparam int unsigned     CW       = clog2(DEPTH) + 1
) (
  input  logic               clk,
  input  logic               inicio_n,
  input  logic               halt,
  input  logic               redirect_valid,
  input  logic [PC_W-1:0]    redirect_pc,
  output logic               imem_en,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [PC_W-1:0]    out_pc,
  output logic [CW-1:0]      count,
  output logic               Test
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]        perf_fetched,
  output logic [31:0]        perf_flushed
`endif
);

  fetch_state_e              state_q, state_d;
  logic [PC_W-1:0]           pc_q, pc_d;
  logic [PC_W-1:0]           req_pc_q, req_pc_d;
  logic                      inflight_q, inflight_d;
  logic [CW-1:0]             fifo_count;
  logic [CW:0]               credit_used;
  logic [INSTR_W+PC_W-1:0]   head;
  logic                      redir;
  logic                      issue;
  logic                      push;
  logic                      pop;

  // Redirects are ignored during the single BOOT cycle.
  assign redir       = redirect_valid && (state_q != ST_BOOT);
  assign credit_used = {1'b0, fifo_count} + {{CW{1'b0}}, inflight_q};
  // Halt suppresses issue in the very cycle it is raised, not just from DRAIN on.
  assign issue       = (state_q == ST_RUN) && !halt && !redirect_valid &&
                       (credit_used < (CW+1)'(DEPTH));
  assign push        = inflight_q && !redir;
  assign pop         = out_valid && out_ready && !redir;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    req_pc_d   = req_pc_q;
    inflight_d = issue;
    if (redir) begin
      pc_d = redirect_pc;
    end else if (issue) begin
      pc_d     = pc_q + PC_W'(PC_STEP);
      req_pc_d = pc_q;
    end
    case (state_q)
      ST_BOOT:   state_d = ST_RUN;
      ST_RUN:    if (halt) state_d = ST_DRAIN;
      ST_DRAIN:  if (!redir && (fifo_count == '0) && !inflight_q) state_d = ST_HALTED;
      ST_HALTED: if (!redir && !halt) state_d = ST_RUN;
      default:   state_d = ST_BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge inicio_n) begin
    if (!inicio_n) begin
      state_q    <= ST_BOOT;
      pc_q       <= RESET_PC;
      req_pc_q   <= '0;
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_pc_q   <= req_pc_d;
      inflight_q <= inflight_d;
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (INSTR_W + PC_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (inicio_n),
    .push  (push),
    .pop   (pop),
    .clear (redir),
    .wdata ({imem_data, req_pc_q}),
    .rdata (head),
    .count (fifo_count)
  );

  assign imem_en   = issue;
  assign imem_addr = pc_q;
  assign out_valid = (fifo_count != '0);
  assign out_instr = head[PC_W +: INSTR_W];
  assign out_pc    = head[PC_W-1:0];
  assign count     = fifo_count;
  assign Test      = (state_q == ST_HALTED);

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetched_q, flushed_q;
  logic [32:0] fetched_sum, flushed_sum;

  // A redirect discards every queued entry plus any response still in flight.
  assign fetched_sum = {1'b0, fetched_q} + 33'(pop);
  assign flushed_sum = {1'b0, flushed_q} + 33'(credit_used);

  always_ff @(posedge clk or negedge inicio_n) begin
    if (!inicio_n) begin
      fetched_q <= '0;
      flushed_q <= '0;
    end else begin
      if (pop)   fetched_q <= fetched_sum[32] ? '1 : fetched_sum[31:0];
      if (redir) flushed_q <= flushed_sum[32] ? '1 : flushed_sum[31:0];
    end
  end

  assign perf_fetched = fetched_q;
  assign perf_flushed = flushed_q;
`else
  // Performance counters are not built in this configuration.
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_queue
// Purpose  : Self-checking bench for fetch_queue (default and 8-bit PC wrap).
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_queue;

  localparam int DEPTH = 4;
  localparam int M_BOOT = 0, M_RUN = 1, M_DRAIN = 2, M_HALTED = 3;

  logic        clk = 1'b0;
  logic        inicio_n = 1'b0;
  logic        halt = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        out_ready = 1'b1;
  logic        imem_en;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        out_valid;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [2:0]  count;
  logic        Test;

  logic        w_en;
  logic [7:0]  w_addr;
  logic [31:0] w_data;
  logic        w_valid;
  logic [31:0] w_instr;
  logic [7:0]  w_pc;
  logic [2:0]  w_count;
  logic        w_test;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched, perf_flushed, w_pf, w_pfl;
`endif

  always #5 clk = ~clk;

  fetch_queue dut (
    .clk(clk), .inicio_n(inicio_n), .halt(halt), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .imem_en(imem_en), .imem_addr(imem_addr),
    .imem_data(imem_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_pc(out_pc), .count(count), .Test(Test)
`ifdef FETCH_PERF_CNT_EN
    , .perf_fetched(perf_fetched), .perf_flushed(perf_flushed)
`endif
  );

  fetch_queue #(.PC_W(8), .RESET_PC(8'hF8)) dut_wrap (
    .clk(clk), .inicio_n(inicio_n), .halt(1'b0), .redirect_valid(1'b0),
    .redirect_pc(8'h00), .imem_en(w_en), .imem_addr(w_addr),
    .imem_data(w_data), .out_valid(w_valid), .out_ready(1'b1),
    .out_instr(w_instr), .out_pc(w_pc), .count(w_count), .Test(w_test)
`ifdef FETCH_PERF_CNT_EN
    , .perf_fetched(w_pf), .perf_flushed(w_pfl)
`endif
  );

  function automatic logic [31:0] fpat(input logic [31:0] a);
    return {~a[15:0], a[15:0]};
  endfunction

  // Synchronous instruction memories, one-cycle latency.
  always @(posedge clk) if (imem_en) imem_data <= fpat(imem_addr);
  always @(posedge clk) if (w_en)    w_data    <= fpat({24'h0, w_addr});

  int tests_run = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct packed { logic [31:0] pc; logic [31:0] instr; } ent_t;
  ent_t        mq[$];
  int          mst;
  logic [31:0] mpc;
  bit          minfl;
  logic [31:0] minfl_pc;

  function automatic bit m_en();
    return (mst == M_RUN) && !halt && !redirect_valid &&
           ((mq.size() + int'(minfl)) < DEPTH);
  endfunction

  task automatic model_reset();
    mq.delete();
    mst   = M_BOOT;
    mpc   = 32'h0;
    minfl = 1'b0;
  endtask

  task automatic model_step();
    bit   en, pop, redir, pre_empty, pre_infl;
    ent_t e;
    en        = m_en();
    pop       = (mq.size() > 0) && out_ready;
    redir     = redirect_valid && (mst != M_BOOT);
    pre_empty = (mq.size() == 0);
    pre_infl  = minfl;
    if (redir) begin
      mq.delete();
      minfl = 1'b0;
      mpc   = redirect_pc;
      if (mst == M_RUN && halt) mst = M_DRAIN;
    end else begin
      if (pop) void'(mq.pop_front());
      if (minfl) begin
        e.pc    = minfl_pc;
        e.instr = fpat(minfl_pc);
        mq.push_back(e);
      end
      minfl = en;
      if (en) begin
        minfl_pc = mpc;
        mpc      = mpc + 32'd4;
      end
      case (mst)
        M_BOOT:   mst = M_RUN;
        M_RUN:    if (halt) mst = M_DRAIN;
        M_DRAIN:  if (pre_empty && !pre_infl) mst = M_HALTED;
        default:  if (!halt) mst = M_RUN;
      endcase
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge inicio_n);
      if (!inicio_n) model_reset();
      else           model_step();
    end
  end

  // Cycle-by-cycle comparison, mid-cycle.
  initial begin
    forever begin
      @(negedge clk);
      chk("imem_en",   imem_en,   m_en());
      chk("imem_addr", imem_addr, mpc);
      chk("out_valid", out_valid, mq.size() > 0);
      chk("count",     count,     mq.size());
      chk("Test",      Test,      mst == M_HALTED);
      if (mq.size() > 0) begin
        chk("out_pc",    out_pc,    mq[0].pc);
        chk("out_instr", out_instr, mq[0].instr);
      end
    end
  end

  // Delivery logs and issue counter.
  logic [31:0] plog[$];
  logic [7:0]  wlog[$];
  logic [31:0] wins[$];
  int          en_cnt = 0;

  always @(posedge clk) begin
    if (inicio_n && out_valid && out_ready && !redirect_valid) plog.push_back(out_pc);
    if (inicio_n && w_valid && wlog.size() < 4) begin
      wlog.push_back(w_pc);
      wins.push_back(w_instr);
    end
    if (imem_en) en_cnt++;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " out_valid"}, out_valid, 0);
    chk({tag, " count"},     count,     0);
    chk({tag, " imem_en"},   imem_en,   0);
    chk({tag, " imem_addr"}, imem_addr, 32'h0);
    chk({tag, " out_pc"},    out_pc,    32'h0);
    chk({tag, " out_instr"}, out_instr, 32'h0);
    chk({tag, " Test"},      Test,      0);
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    int          mark, en_mark;
    logic [31:0] nxt;
    logic [7:0]  wexp [4];
    wexp[0] = 8'hF8; wexp[1] = 8'hFC; wexp[2] = 8'h00; wexp[3] = 8'h04;

    tick(2);
    #1;
    chk_reset_outputs("rst");
    chk("wrap rst addr", w_addr, 8'hF8);

    @(posedge clk); #2;
    inicio_n = 1'b1;
    tick(1);
    chk("lat c1 valid", out_valid, 0);
    chk("lat c1 en", imem_en, 1);
    tick(1);
    chk("lat c2 valid", out_valid, 0);
    tick(1);
    chk("lat c3 valid", out_valid, 1);
    chk("first pc", out_pc, 32'h0);
    chk("first instr", out_instr, 32'hFFFF_0000);
    tick(6);
    chk("seq size", plog.size() >= 4, 1);
    chk("seq 0", plog[0], 32'h0);
    chk("seq 1", plog[1], 32'h4);
    chk("seq 2", plog[2], 32'h8);
    chk("seq 3", plog[3], 32'hC);

    // Backpressure: queue fills to DEPTH and issue stops.
    out_ready = 1'b0;
    tick(10);
    chk("full count", count, 4);
    chk("full en", imem_en, 0);
    chk("issues=pops+4", en_cnt, plog.size() + 4);
    tick(3);
    chk("full hold count", count, 4);
    out_ready = 1'b1;
    tick(12);
    for (int i = 0; i < plog.size(); i++) chk("order", plog[i], 32'(i * 4));

    // Redirect with three queued and one in flight.
    out_ready = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (mq.size() == 3 && minfl) break;
      tick(1);
    end
    chk("pre-redir count", count, 3);
    mark = plog.size();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h100;
    out_ready      = 1'b1;
    tick(1);
    redirect_valid = 1'b0;
    chk("redir count", count, 0);
    chk("redir valid", out_valid, 0);
    chk("redir addr", imem_addr, 32'h100);
    chk("redir no pop", plog.size(), mark);
`ifdef FETCH_PERF_CNT_EN
    chk("perf_flushed", perf_flushed, 4);
`endif
    for (int k = 0; k < 10; k++) begin
      if (out_valid) break;
      tick(1);
    end
    chk("post-redir pc", out_pc, 32'h100);
    chk("post-redir instr", out_instr, 32'hFEFF_0100);
    tick(4);
    chk("post-redir seq0", plog[mark], 32'h100);
    chk("post-redir seq1", plog[mark+1], 32'h104);

    // Halt with two queued.
    out_ready = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (mq.size() == 2) break;
      tick(1);
    end
    chk("pre-halt count", count, 2);
    halt    = 1'b1;
    en_mark = en_cnt;
    #1;
    chk("halt en", imem_en, 0);
    tick(5);
    chk("halt no issue", en_cnt, en_mark);
    chk("halt not yet", Test, 0);
    out_ready = 1'b1;
    for (int k = 0; k < 12; k++) begin
      if (Test) break;
      tick(1);
    end
    chk("halted Test", Test, 1);
    chk("halted count", count, 0);
    chk("halted no issue", en_cnt, en_mark);
    nxt = plog[plog.size()-1] + 32'd4;
    chk("halted addr", imem_addr, nxt);
    halt = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (out_valid) break;
      tick(1);
    end
    chk("resume pc", out_pc, nxt);

    // Asynchronous reset with three queued.
    out_ready = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (mq.size() == 3) break;
      tick(1);
    end
    chk("pre-reset count", count, 3);
    #1;
    inicio_n = 1'b0;
    #1;
    chk_reset_outputs("async");
    tick(2);
    inicio_n  = 1'b1;
    out_ready = 1'b1;
    mark = plog.size();
    tick(7);
    chk("restart seq0", plog[mark], 32'h0);
    chk("restart seq1", plog[mark+1], 32'h4);
`ifdef FETCH_PERF_CNT_EN
    chk("perf_fetched", perf_fetched, plog.size() - mark);
`endif

    // 8-bit PC wrap instance.
    chk("wrap size", wlog.size(), 4);
    for (int i = 0; i < 4; i++) begin
      chk("wrap pc", wlog[i], wexp[i]);
      chk("wrap instr", wins[i], fpat({24'h0, wexp[i]}));
    end
    chk("wrap steady count", w_count, 1);
    chk("wrap Test", w_test, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Parametrised fetch stage for the pipelined processor (Pipe).
- Generates sequential PCs and issues reads to a synchronous instruction memory (block-RAM IP core, 1-cycle read latency).
- Buffers returned instructions in a DEPTH-entry queue with valid/ready hand-off to decode.
- Supports branch redirect/flush, halt/drain and a Test status flag.

Parameters:
- PC_W, 32, program counter width in bits.
- INSTR_W, 32, instruction width in bits.
- DEPTH, 4, queue entries; power of two, >= 2.
- RESET_PC, 0, PC loaded on reset.
- PC_STEP, 4, PC increment per fetched instruction.

Ports:
- clk  in  1  system clock, rising edge.
- inicio_n  in  1  asynchronous active-low reset.
- halt  in  1  stop issuing new fetches; drain queue.
- redirect_valid  in  1  branch/jump taken; flush and reload PC.
- redirect_pc  in  PC_W  new fetch target.
- imem_en  out  1  memory read enable.
- imem_addr  out  PC_W  memory read address.
- imem_data  in  INSTR_W  read data, valid the cycle after imem_en.
- out_valid  out  1  queue head holds an instruction.
- out_ready  in  1  decode accepts head.
- out_instr  out  INSTR_W  head instruction.
- out_pc  out  PC_W  PC of head instruction.
- count  out  $clog2(DEPTH)+1  occupied entries.
- Test  out  1  high when HALTED.

Behaviour:
- Reset (inicio_n=0, async):
  - pc=RESET_PC; queue empty, count=0.
  - imem_en=0, imem_addr=RESET_PC, out_valid=0, out_instr=0, out_pc=0, Test=0.
  - Inflight flag cleared; FSM=BOOT.
- FSM states:
  - BOOT: one cycle, no request, then RUN.
  - RUN: issue when credit allows. Goes to DRAIN on halt=1.
  - DRAIN: no new requests; waits for inflight=0 and count=0, then HALTED.
  - HALTED: Test=1. halt=0 returns to RUN.
- Issue rule:
  - imem_en=1 in RUN only when count + inflight < DEPTH and redirect_valid=0.
  - imem_addr=pc. Each issue does pc += PC_STEP (mod 2^PC_W, wraps) and sets inflight=1 for the next cycle.
- Response: the cycle after an issue, {imem_data, issued pc} is written to the tail unless a flush killed the request.
- Hand-off:
  - out_valid=1 when count>0. Pop on out_valid & out_ready.
  - Push and pop in the same cycle leave count unchanged.
  - Outputs are registered from the queue head; zero-cycle bypass from memory to output is forbidden.
- Fetch latency: the first instruction after BOOT appears on out_valid at cycle 3 after reset release (BOOT, issue, write).
- Redirect (any state except BOOT):
  - Queue cleared, count=0, out_valid=0 next cycle.
  - Inflight response discarded; pc=redirect_pc.
  - No issue in the redirect cycle.
  - From DRAIN/HALTED the FSM stays put; only the PC is updated.
- Simultaneous events:
  - Redirect beats pop and push.
  - Halt with redirect: PC updated, FSM enters DRAIN.
- Full: no issue while count+inflight=DEPTH. out_ready backpressure never loses data.
- Reset mid-operation: all state abandoned immediately; inflight data ignored.

Optional Feature:
- Macro: FETCH_PERF_CNT_EN.
- Defined: adds output ports perf_fetched (32) and perf_flushed (32).
  - perf_fetched counts pops.
  - perf_flushed counts entries plus inflight requests discarded by redirect.
  - Both saturate at all-ones and reset to 0.
- Undefined: ports and logic absent; all other behaviour identical.

Decomposition:
- Package fetch_pkg holds:
  - FSM state encoding (BOOT, RUN, DRAIN, HALTED).
  - Default widths.
  - Count-width function clog2.
- One sub-module: fetch_fifo, a synchronous DEPTH x (INSTR_W+PC_W) circular buffer with push, pop, clear and count, wrap by pointer mask.
- fetch_queue contains the PC, FSM, inflight tracking and credit logic.

Test Plan:
- Reset, out_ready=1, imem_data=addr-derived pattern:
  - out_pc sequence 0,4,8,12…
  - First out_valid 3 cycles after inicio_n rises.
- out_ready=0, DEPTH=4:
  - Exactly 4 issues; count=4; imem_en stays 0.
  - Raising out_ready drains in order, no loss or duplicate.
- redirect_valid with redirect_pc=0x100 while 3 entries queued and one inflight:
  - count=0 next cycle.
  - Next delivered out_pc=0x100; stale data never appears.
  - Perf build: perf_flushed=4.
- halt=1 with 2 queued:
  - No further imem_en.
  - After both are popped, Test=1.
  - halt=0 resumes at next sequential PC.
- PC wrap, PC_W=8, RESET_PC=0xF8:
  - Sequence F8, FC, 00, 04.
- inicio_n pulled low mid-stream with count=3:
  - All outputs return to reset values asynchronously.
  - Fetch restarts at RESET_PC.
